wallace_mac: RTL and testbench

WALLACE_MAC -- requirements
Module: wallace_mac

---
 rtl/wallace_mac.sv | 177 +++++++++++++++++
 tb/tb_wallace_mac.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wallace_mac.sv
// Burst multiply-accumulate around a 4x4 Wallace multiplier, valid/ready on both sides.
// Optional WALLACE_MAC_SATURATE_EN clamps the accumulator instead of wrapping.

module wallace_mul4 (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    output logic [7:0] o_p
);
    logic [7:0] w_r0, w_r1, w_r2, w_r3;
    logic [7:0] w_s1, w_m1, w_c1;
    logic [7:0] w_s2, w_m2, w_c2;

    assign w_r0 = {4'b0, i_a & {4{i_b[0]}}};
    assign w_r1 = {3'b0, i_a & {4{i_b[1]}}, 1'b0};
    assign w_r2 = {2'b0, i_a & {4{i_b[2]}}, 2'b0};
    assign w_r3 = {1'b0, i_a & {4{i_b[3]}}, 3'b0};

    // Two carry-save levels reduce four rows to two, then one carry-propagate add.
    assign w_s1 = w_r0 ^ w_r1 ^ w_r2;
    assign w_m1 = (w_r0 & w_r1) | (w_r0 & w_r2) | (w_r1 & w_r2);
    assign w_c1 = {w_m1[6:0], 1'b0};

    assign w_s2 = w_s1 ^ w_c1 ^ w_r3;
    assign w_m2 = (w_s1 & w_c1) | (w_s1 & w_r3) | (w_c1 & w_r3);
    assign w_c2 = {w_m2[6:0], 1'b0};

    assign o_p = w_s2 + w_c2;
endmodule

module wallace_mac #(
    parameter int ACC_W     = 10,
    parameter int BURST_MAX = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       A,
    input  logic [3:0]       B,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic [4:0]       beat_cnt,
    output logic             ovf
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [7:0]       w_prod;
    logic [7:0]       r_prod;
    logic             r_p_valid;
    logic             r_p_last;
    logic [4:0]       r_in_cnt;
    logic [ACC_W-1:0] r_acc;
    logic [4:0]       r_cnt;
    logic             r_ovf;

    logic             w_accept;
    logic             w_last;
    logic             w_release;
    logic [ACC_W:0]   w_sum;
    logic [ACC_W-1:0] w_acc_nxt;

    wallace_mul4 u_mul (
        .i_a (A),
        .i_b (B),
        .o_p (w_prod)
    );

    assign w_accept  = in_valid & in_ready;
    assign w_last    = in_last | (r_in_cnt == 5'(BURST_MAX - 1));
    assign w_release = (r_state == S_DONE) & out_ready;

    assign w_sum = {1'b0, r_acc} + (ACC_W + 1)'(r_prod);

`ifdef WALLACE_MAC_SATURATE_EN
    // Once clamped, the accumulator stays pinned for the rest of the burst.
    assign w_acc_nxt = (r_ovf | w_sum[ACC_W]) ? {ACC_W{1'b1}}
                                              : w_sum[ACC_W-1:0];
`else
    assign w_acc_nxt = w_sum[ACC_W-1:0];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (clr) begin
            w_state_nxt = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE, S_ACCUM: begin
                    if (w_accept) begin
                        w_state_nxt = w_last ? S_FLUSH : S_ACCUM;
                    end
                end
                S_FLUSH: begin
                    if (r_p_valid && r_p_last) begin
                        w_state_nxt = S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        if (!rst && (r_state == S_IDLE || r_state == S_ACCUM)) begin
            in_ready = 1'b1;
        end
        if (r_state == S_DONE) begin
            out_valid = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prod    <= '0;
            r_p_valid <= 1'b0;
            r_p_last  <= 1'b0;
            r_in_cnt  <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
        end else if (clr) begin
            r_p_valid <= 1'b0;
            r_p_last  <= 1'b0;
            r_in_cnt  <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_p_valid <= w_accept;
            r_p_last  <= w_accept & w_last;
            if (w_accept) begin
                r_prod   <= w_prod;
                r_in_cnt <= r_in_cnt + 5'd1;
            end
            if (w_release) begin
                r_in_cnt <= '0;
                r_acc    <= '0;
                r_cnt    <= '0;
                r_ovf    <= 1'b0;
            end else if (r_p_valid) begin
                r_acc <= w_acc_nxt;
                r_cnt <= r_cnt + 5'd1;
                r_ovf <= r_ovf | w_sum[ACC_W];
            end
        end
    end

    assign acc_out  = r_acc;
    assign beat_cnt = r_cnt;
    assign ovf      = r_ovf;
endmodule

// File: tb/tb_wallace_mac.sv
// Directed and random bursts for wallace_mac, checked against an arithmetic model.
// Build with or without WALLACE_MAC_SATURATE_EN; the model follows the same macro.

module tb_wallace_mac;
    localparam int ACC_W     = 10;
    localparam int BURST_MAX = 16;
    localparam int ACC_MAX   = (1 << ACC_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             clr;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       A;
    logic [3:0]       B;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] acc_out;
    logic [4:0]       beat_cnt;
    logic             ovf;

    int checks = 0;
    int errors = 0;
    int qa[32];
    int qb[32];

    wallace_mac #(.ACC_W(ACC_W), .BURST_MAX(BURST_MAX)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc_out   (acc_out),
        .beat_cnt  (beat_cnt),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    // Sum of products with per-step overflow detection.
    task automatic model(input int n, output int acc, output int ov);
        int t;
        acc = 0;
        ov  = 0;
        for (int i = 0; i < n; i++) begin
            t = acc + qa[i] * qb[i];
            if (t > ACC_MAX) ov = 1;
`ifdef WALLACE_MAC_SATURATE_EN
            acc = (t > ACC_MAX) ? ACC_MAX : t;
`else
            acc = t % (ACC_MAX + 1);
`endif
        end
    endtask

    task automatic beat(input int a, input int b, input logic last);
        int w = 0;
        A        = 4'(a);
        B        = 4'(b);
        in_last  = last;
        in_valid = 1'b1;
        while (!in_ready && w < 50) begin
            tick();
            w++;
        end
        check("ready_wait", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic run_burst(input int n, input bit use_last,
                             input int hold, input bit gaps);
        int exp_acc, exp_ovf, eff;
        eff = (n > BURST_MAX) ? BURST_MAX : n;
        model(eff, exp_acc, exp_ovf);
        out_ready = (hold == 0);
        for (int i = 0; i < eff; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) tick();
            beat(qa[i], qb[i], use_last && (i == eff - 1));
            check("mid_cnt", 32'(beat_cnt), 32'(i));
        end
        check("flush_ready", 32'(in_ready), 0);
        check("flush_ov", 32'(out_valid), 0);
        tick();
        check("done_ov", 32'(out_valid), 1);
        check("done_acc", 32'(acc_out), 32'(exp_acc));
        check("done_cnt", 32'(beat_cnt), 32'(eff));
        check("done_ovf", 32'(ovf), 32'(exp_ovf));
        for (int h = 0; h < hold; h++) begin
            tick();
            check("hold_ov", 32'(out_valid), 1);
            check("hold_acc", 32'(acc_out), 32'(exp_acc));
            check("hold_cnt", 32'(beat_cnt), 32'(eff));
            check("hold_ready", 32'(in_ready), 0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("rel_ov", 32'(out_valid), 0);
        check("rel_acc", 32'(acc_out), 0);
        check("rel_cnt", 32'(beat_cnt), 0);
        check("rel_ovf", 32'(ovf), 0);
        check("rel_ready", 32'(in_ready), 1);
    endtask

    initial begin
        int n;
        rst       = 1'b1;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        A         = '0;
        B         = '0;

        // Reset with random inputs: every output must be zero.
        for (int i = 0; i < 4; i++) begin
            in_valid  = 1'($urandom);
            in_last   = 1'($urandom);
            clr       = 1'($urandom);
            out_ready = 1'($urandom);
            A         = 4'($urandom);
            B         = 4'($urandom);
            tick();
            check("rst_ready", 32'(in_ready), 0);
            check("rst_ov", 32'(out_valid), 0);
            check("rst_acc", 32'(acc_out), 0);
            check("rst_cnt", 32'(beat_cnt), 0);
            check("rst_ovf", 32'(ovf), 0);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        clr       = 1'b0;
        out_ready = 1'b0;
        rst       = 1'b0;
        #1;
        check("post_rst_ready", 32'(in_ready), 1);
        tick();

        // Three-beat burst: 15 + 225 + 14 = 254.
        qa[0] = 3;  qb[0] = 5;
        qa[1] = 15; qb[1] = 15;
        qa[2] = 2;  qb[2] = 7;
        run_burst(3, 1, 0, 0);

        // Five full-scale beats overflow a 10-bit accumulator.
        for (int i = 0; i < 5; i++) begin
            qa[i] = 15;
            qb[i] = 15;
        end
        run_burst(5, 1, 0, 0);

        // Implicit last at BURST_MAX, result held 10 cycles.
        for (int i = 0; i < 16; i++) begin
            qa[i] = 1;
            qb[i] = 1;
        end
        run_burst(16, 0, 10, 0);

        // Zero operands still count as beats.
        qa[0] = 0; qb[0] = 9;
        qa[1] = 7; qb[1] = 0;
        qa[2] = 4; qb[2] = 4;
        run_burst(3, 1, 1, 0);

        // Abort after two beats while a third is offered.
        beat(5, 5, 1'b0);
        beat(6, 6, 1'b0);
        A        = 4'd9;
        B        = 4'd9;
        in_valid = 1'b1;
        clr      = 1'b1;
        tick();
        clr      = 1'b0;
        in_valid = 1'b0;
        check("clr_acc", 32'(acc_out), 0);
        check("clr_cnt", 32'(beat_cnt), 0);
        check("clr_ready", 32'(in_ready), 1);
        check("clr_ov", 32'(out_valid), 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("clr_idle_ov", 32'(out_valid), 0);
            check("clr_idle_acc", 32'(acc_out), 0);
        end

        // Reset mid-burst discards everything in flight.
        beat(3, 3, 1'b0);
        beat(4, 4, 1'b1);
        rst = 1'b1;
        #1;
        check("mid_rst_ready", 32'(in_ready), 0);
        check("mid_rst_cnt", 32'(beat_cnt), 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_mid_rst_ov", 32'(out_valid), 0);
            check("post_mid_rst_acc", 32'(acc_out), 0);
        end

        // Random bursts with gaps and random consumer stalls.
        for (int k = 0; k < 8; k++) begin
            n = $urandom_range(1, BURST_MAX);
            for (int i = 0; i < n; i++) begin
                qa[i] = $urandom_range(0, 15);
                qb[i] = $urandom_range(0, 15);
            end
            run_burst(n, (n < BURST_MAX) ? 1'b1 : 1'($urandom),
                      $urandom_range(0, 3), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
